// File: rtl/qkt_pkg.sv
// Shared definitions for the qkt operand server: FSM states, default
// geometry and the K-buffer address helper.
package qkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        LOAD_K,
        KICK,
        RUN
    } state_t;

    localparam int DEF_INPUT_WIDTH  = 8;
    localparam int DEF_D_K          = 64;
    localparam int DEF_MAX_NUM_KEYS = 128;
    localparam int DEF_IDX_WIDTH    = 11;
    localparam int DEF_NK_WIDTH     = 9;

    // Flat row-major address of K[row][col]; callers truncate to their depth.
    function automatic logic [31:0] k_addr(input logic [31:0] row,
                                           input logic [31:0] col,
                                           input logic [31:0] dk);
        return row * dk + col;
    endfunction

endpackage

// File: rtl/qkt_operand_mem.sv
// Operand storage: Q row register file and K matrix with one write port each
// and a combinational, range-checked read port shared by the engine.
module qkt_operand_mem
    import qkt_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int D_K          = DEF_D_K,
    parameter int MAX_NUM_KEYS = DEF_MAX_NUM_KEYS,
    parameter int IDX_WIDTH    = DEF_IDX_WIDTH,
    parameter int NK_WIDTH     = DEF_NK_WIDTH
) (
    input  logic                          clk,
    input  logic                          q_we,
    input  logic [$clog2(D_K)-1:0]        q_waddr,
    input  logic                          k_we,
    input  logic [NK_WIDTH-1:0]           k_row,
    input  logic [$clog2(D_K)-1:0]        k_col,
    input  logic [INPUT_WIDTH-1:0]        wdata,
    input  logic [NK_WIDTH-1:0]           num_keys,
    input  logic [IDX_WIDTH-1:0]          dk_idx,
    input  logic [IDX_WIDTH-1:0]          key_idx,
    output logic [INPUT_WIDTH-1:0]        q_i,
    output logic [INPUT_WIDTH-1:0]        k_j,
    output logic                          dk_ok,
    output logic                          key_ok
);

    localparam int CW     = $clog2(D_K);
    localparam int KDEPTH = MAX_NUM_KEYS * D_K;
    localparam int KAW    = $clog2(KDEPTH);

    logic signed [INPUT_WIDTH-1:0] q_mem [D_K];
    logic signed [INPUT_WIDTH-1:0] k_mem [KDEPTH];
    logic [KAW-1:0]                k_waddr;
    logic [KAW-1:0]                k_raddr;

    assign k_waddr = KAW'(k_addr(32'(k_row), 32'(k_col), 32'(D_K)));
    assign k_raddr = KAW'(k_addr(32'(key_idx), 32'(dk_idx), 32'(D_K)));

    // Indices past the loaded geometry read as zero; the address is only
    // used once both indices are known to be in range.
    assign dk_ok  = 32'(dk_idx) < 32'(D_K);
    assign key_ok = 32'(key_idx) < 32'(num_keys);
    assign q_i    = dk_ok ? q_mem[dk_idx[CW-1:0]] : '0;
    assign k_j    = (dk_ok && key_ok) ? k_mem[k_raddr] : '0;

    // Operand writes from the load stream; contents are never reset.
    always_ff @(posedge clk) begin
        if (q_we) q_mem[q_waddr] <= $signed(wdata);
        if (k_we) k_mem[k_waddr] <= $signed(wdata);
    end

endmodule

// File: rtl/qkt_operand_server.sv
// Loads one Q row and a K matrix from a byte stream, kicks the softmax
// engine, and serves operands combinationally while the engine sweeps.
module qkt_operand_server
    import qkt_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int D_K          = DEF_D_K,
    parameter int MAX_NUM_KEYS = DEF_MAX_NUM_KEYS,
    parameter int IDX_WIDTH    = DEF_IDX_WIDTH,
    parameter int NK_WIDTH     = DEF_NK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic [NK_WIDTH-1:0]    cfg_num_keys,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [INPUT_WIDTH-1:0] s_data,
    input  logic [IDX_WIDTH-1:0]   dk_idx,
    input  logic [IDX_WIDTH-1:0]   key_idx,
    output logic [INPUT_WIDTH-1:0] q_i,
    output logic [INPUT_WIDTH-1:0] k_j,
    output logic                   sm_start,
    output logic [NK_WIDTH-1:0]    sm_num_queries,
    input  logic                   sm_done,
    output logic                   busy,
    output logic                   err_cfg,
    output logic                   err_oob
);

    localparam int CW = $clog2(D_K);

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       q_cnt;
    logic [CW-1:0]       col;
    logic [NK_WIDTH-1:0] row;
    logic                cfg_ok;
    logic                load_go;
    logic                q_we;
    logic                k_we;
    logic                last_col;
    logic                dk_ok;
    logic                key_ok;

    assign cfg_ok   = (cfg_num_keys != '0) && (32'(cfg_num_keys) <= 32'(MAX_NUM_KEYS));
    assign load_go  = (state_q == IDLE) && load_start;
    assign last_col = (col == CW'(D_K - 1));
    // s_ready is a pure function of state, so s_valid alone qualifies a beat here.
    assign q_we     = (state_q == LOAD_Q) && s_valid;
    assign k_we     = (state_q == LOAD_K) && s_valid;
    assign busy     = (state_q != IDLE);

    // Next-state logic plus the stream handshake and engine start strobe.
    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        sm_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start && cfg_ok) state_d = LOAD_Q;
            end
            LOAD_Q: begin
                s_ready = 1'b1;
                if (s_valid && (q_cnt == CW'(D_K - 1))) state_d = LOAD_K;
            end
            LOAD_K: begin
                s_ready = 1'b1;
                if (s_valid && last_col && (row == sm_num_queries - NK_WIDTH'(1)))
                    state_d = KICK;
            end
            KICK: begin
                sm_start = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (sm_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Load counters, latched key count and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt          <= '0;
            col            <= '0;
            row            <= '0;
            sm_num_queries <= '0;
            err_cfg        <= 1'b0;
            err_oob        <= 1'b0;
        end else begin
            if (load_go) begin
                if (cfg_ok) begin
                    sm_num_queries <= cfg_num_keys;
                    err_cfg        <= 1'b0;
                    err_oob        <= 1'b0;
                    q_cnt          <= '0;
                    col            <= '0;
                    row            <= '0;
                end else begin
                    err_cfg <= 1'b1;
                end
            end
            if (q_we) q_cnt <= q_cnt + 1'b1;
            if (k_we) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if ((state_q == RUN) && !(dk_ok && key_ok)) err_oob <= 1'b1;
        end
    end

    qkt_operand_mem #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .D_K          (D_K),
        .MAX_NUM_KEYS (MAX_NUM_KEYS),
        .IDX_WIDTH    (IDX_WIDTH),
        .NK_WIDTH     (NK_WIDTH)
    ) u_mem (
        .clk      (clk),
        .q_we     (q_we),
        .q_waddr  (q_cnt),
        .k_we     (k_we),
        .k_row    (row),
        .k_col    (col),
        .wdata    (s_data),
        .num_keys (sm_num_queries),
        .dk_idx   (dk_idx),
        .key_idx  (key_idx),
        .q_i      (q_i),
        .k_j      (k_j),
        .dk_ok    (dk_ok),
        .key_ok   (key_ok)
    );

endmodule

// File: tb/tb_qkt_operand_server.sv
// Directed-plus-random bench for qkt_operand_server with an array-based
// operand model and a simple engine stand-in that sweeps all indices.
module tb_qkt_operand_server;

    localparam int DW   = 8;
    localparam int DK   = 64;
    localparam int MAXK = 128;
    localparam int IW   = 11;
    localparam int NW   = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [NW-1:0] cfg_num_keys;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [IW-1:0] dk_idx;
    logic [IW-1:0] key_idx;
    logic [DW-1:0] q_i;
    logic [DW-1:0] k_j;
    logic          sm_start;
    logic [NW-1:0] sm_num_queries;
    logic          sm_done;
    logic          busy;
    logic          err_cfg;
    logic          err_oob;

    qkt_operand_server dut (
        .clk            (clk),
        .rst            (rst),
        .load_start     (load_start),
        .cfg_num_keys   (cfg_num_keys),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .dk_idx         (dk_idx),
        .key_idx        (key_idx),
        .q_i            (q_i),
        .k_j            (k_j),
        .sm_start       (sm_start),
        .sm_num_queries (sm_num_queries),
        .sm_done        (sm_done),
        .busy           (busy),
        .err_cfg        (err_cfg),
        .err_oob        (err_oob)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int q_m [DK];
    int k_m [MAXK][DK];
    int model_nk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_q(input int dk);
        return (dk < DK) ? q_m[dk] : 0;
    endfunction

    function automatic int exp_k(input int key, input int dk);
        return (dk < DK && key < model_nk) ? k_m[key][dk] : 0;
    endfunction

    function automatic logic [DW-1:0] beat_val(input int i);
        if (i < DK) return DW'(q_m[i]);
        return DW'(k_m[(i - DK) / DK][(i - DK) % DK]);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int nk, input bit rnd);
        for (int i = 0; i < DK; i++) q_m[i] = rnd ? int'($urandom_range(255)) : i;
        for (int r = 0; r < nk; r++)
            for (int c = 0; c < DK; c++)
                k_m[r][c] = rnd ? int'($urandom_range(255)) : ((r * DK + c) & 255);
    endtask

    // Full load when stop_after < 0, otherwise stop after that many beats.
    task automatic do_load(input int nk, input bit gaps, input bit rnd, input int stop_after);
        int total;
        int idx;
        int budget;
        int starts;
        bit accept;
        fill(nk, rnd);
        load_start   = 1'b1;
        cfg_num_keys = NW'(nk);
        tick;
        load_start = 1'b0;
        model_nk   = nk;
        chk("load_busy", 32'(busy), 1);
        chk("load_err_cleared", {30'd0, err_cfg, err_oob}, 0);
        total  = (stop_after < 0) ? DK + nk * DK : stop_after;
        idx    = 0;
        budget = 0;
        starts = 0;
        while (idx < total && budget < 40 * total + 100) begin
            s_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
            s_data  = beat_val(idx);
            #1;
            if (sm_start) starts++;
            accept = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (accept) idx++;
            budget++;
        end
        s_valid = 1'b0;
        chk("load_beats", idx, total);
        chk("load_no_early_start", starts, 0);
        if (!gaps) chk("gapless_cycles", budget, total);
        if (stop_after < 0) begin
            chk("kick_start", 32'(sm_start), 1);
            chk("kick_ready", 32'(s_ready), 0);
            chk("sm_num_queries", 32'(sm_num_queries), nk);
            tick;
            chk("run_start_low", 32'(sm_start), 0);
            chk("run_busy", 32'(busy), 1);
        end
    endtask

    // Engine stand-in: one index pair per cycle over the loaded geometry.
    task automatic sweep(input int nk);
        for (int key = 0; key < nk; key++)
            for (int dk = 0; dk < DK; dk++) begin
                key_idx = IW'(key);
                dk_idx  = IW'(dk);
                #1;
                chk("sweep_q", 32'(q_i), exp_q(dk));
                chk("sweep_k", 32'(k_j), exp_k(key, dk));
                tick;
            end
        key_idx = '0;
        dk_idx  = '0;
    endtask

    task automatic finish_run;
        sm_done = 1'b1;
        tick;
        sm_done = 1'b0;
        chk("done_idle", 32'(busy), 0);
        chk("done_ready", 32'(s_ready), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; cfg_num_keys = '0; s_valid = 1'b0;
        s_data = '0; dk_idx = '0; key_idx = '0; sm_done = 1'b0;
        #1;
        repeat (3) tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_start", 32'(sm_start), 0);
        chk("rst_errs", {30'd0, err_cfg, err_oob}, 0);
        chk("rst_nq", 32'(sm_num_queries), 0);
        rst = 1'b0;
        tick;

        // sm_done in IDLE must not disturb anything
        sm_done = 1'b1;
        tick;
        sm_done = 1'b0;
        chk("idle_done_ignored", 32'(busy), 0);

        // Basic load, 4 keys, counting pattern
        do_load(4, 1'b0, 1'b0, -1);
        dk_idx = 11'd5; key_idx = 11'd3;
        #1;
        chk("basic_q5", 32'(q_i), 32'h05);
        chk("basic_k3_5", 32'(k_j), 32'hC5);
        tick;
        sweep(4);
        chk("clean_run_no_oob", 32'(err_oob), 0);

        // Out-of-range reads in RUN
        key_idx = 11'd4; dk_idx = 11'd0;
        #1;
        chk("oob_key_zero", 32'(k_j), 0);
        tick;
        chk("oob_flag", 32'(err_oob), 1);
        key_idx = 11'd0; dk_idx = 11'd64;
        #1;
        chk("oob_dk_q_zero", 32'(q_i), 0);
        chk("oob_dk_k_zero", 32'(k_j), 0);
        tick;
        dk_idx = 11'd0;

        // load_start during RUN is ignored
        load_start = 1'b1; cfg_num_keys = 9'd2;
        tick;
        load_start = 1'b0;
        chk("run_ls_busy", 32'(busy), 1);
        chk("run_ls_ready", 32'(s_ready), 0);
        chk("run_ls_nq", 32'(sm_num_queries), 4);
        chk("run_ls_start", 32'(sm_start), 0);
        finish_run;
        chk("oob_sticky", 32'(err_oob), 1);
        dk_idx = 11'd5; key_idx = 11'd3;
        #1;
        chk("idle_read_k", 32'(k_j), 32'hC5);
        tick;

        // Rejected configurations
        load_start = 1'b1; cfg_num_keys = 9'd0;
        tick;
        load_start = 1'b0;
        chk("cfg0_err", 32'(err_cfg), 1);
        chk("cfg0_busy", 32'(busy), 0);
        chk("cfg0_ready", 32'(s_ready), 0);
        err_check_129 : begin
            load_start = 1'b1; cfg_num_keys = 9'd129;
            tick;
            load_start = 1'b0;
            chk("cfg129_err", 32'(err_cfg), 1);
            chk("cfg129_busy", 32'(busy), 0);
            chk("cfg129_ready", 32'(s_ready), 0);
            chk("cfg_bad_nq_kept", 32'(sm_num_queries), 4);
            chk("cfg_bad_oob_kept", 32'(err_oob), 1);
        end

        // Backpressured single-key load, counting pattern
        do_load(1, 1'b1, 1'b0, -1);
        sweep(1);
        finish_run;

        // Random contents and key counts
        repeat (2) begin
            int nk;
            nk = int'($urandom_range(8, 2));
            do_load(nk, 1'($urandom_range(1)), 1'b1, -1);
            sweep(nk);
            chk("rand_no_oob", 32'(err_oob), 0);
            finish_run;
        end

        // Reset in the middle of LOAD_K
        do_load(4, 1'b0, 1'b1, DK + 10);
        rst = 1'b1;
        repeat (3) tick;
        chk("midrst_ready", 32'(s_ready), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_nq", 32'(sm_num_queries), 0);
        rst = 1'b0;
        model_nk = 0;
        dk_idx = 11'd7; key_idx = 11'd0;
        #1;
        chk("midrst_q_kept", 32'(q_i), exp_q(7));
        chk("midrst_k_zero", 32'(k_j), 0);
        tick;
        dk_idx = '0;
        do_load(2, 1'b0, 1'b1, -1);
        sweep(2);
        finish_run;

        // Full-depth load
        do_load(MAXK, 1'b0, 1'b1, -1);
        sweep(MAXK);
        chk("max_no_oob", 32'(err_oob), 0);
        key_idx = 11'd128; dk_idx = 11'd0;
        #1;
        chk("max_oob_k_zero", 32'(k_j), 0);
        tick;
        chk("max_oob_flag", 32'(err_oob), 1);
        key_idx = '0;
        finish_run;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qkt_operand_server.md
Name: qkt_operand_server

Overview:
- Operand-side partner of qkt_softmax: buffers one Q row and a K matrix, then serves q_i/k_j to the engine as it sweeps dk_idx/key_idx.
- Host loads operands over a valid/ready byte stream. The block kicks the engine with a start pulse and waits for done before the next load.
- Sits between the host/DMA stream and the qkt_softmax operand ports.

Parameters:
- INPUT_WIDTH, 8, operand width (Q0.7 signed).
- D_K, 64, key dimension (power of 2).
- MAX_NUM_KEYS, 128, key-buffer depth in rows.
- IDX_WIDTH, 11, width of engine index ports.
- NK_WIDTH, 9, width of key-count fields.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- load_start  in  1  begin load; samples cfg_num_keys
- cfg_num_keys  in  NK_WIDTH  number of K rows for this run
- s_valid  in  1  load-stream beat valid
- s_ready  out  1  load-stream beat accepted when s_valid&s_ready
- s_data  in  INPUT_WIDTH  load-stream operand byte
- dk_idx  in  IDX_WIDTH  engine element index
- key_idx  in  IDX_WIDTH  engine key-row index
- q_i  out  INPUT_WIDTH  Q[dk_idx]
- k_j  out  INPUT_WIDTH  K[key_idx][dk_idx]
- sm_start  out  1  one-cycle engine start pulse
- sm_num_queries  out  NK_WIDTH  latched key count to engine num_queries
- sm_done  in  1  engine completion
- busy  out  1  high in every state except IDLE
- err_cfg  out  1  sticky: rejected cfg_num_keys
- err_oob  out  1  sticky: out-of-range index during RUN

Behaviour:
- Single clock domain. Reset is synchronous, active-high, taken on clk rising edge and overriding all other inputs.
- Reset values: state=IDLE; s_ready, sm_start, busy, err_cfg, err_oob = 0; sm_num_queries=0; load counters=0. Buffer contents are not cleared and are don't-care.
- FSM states and transitions:
  - IDLE, on load_start:
    - If cfg_num_keys is in 1..MAX_NUM_KEYS: latch it into sm_num_queries, clear err_cfg and err_oob, go to LOAD_Q.
    - Otherwise set err_cfg and stay in IDLE.
  - LOAD_Q: s_ready=1. Each accepted beat is written to Q[q_cnt] and q_cnt increments. The beat with q_cnt==D_K-1 moves the FSM to LOAD_K.
  - LOAD_K: s_ready=1. Beats are written row-major to K[row][col]; col wraps at D_K-1 and row then increments. The beat at row==num_keys-1 and col==D_K-1 moves the FSM to KICK.
  - KICK: sm_start=1 for exactly one cycle, then RUN.
  - RUN: on sm_done=1, go to IDLE.
- Latency: last K beat accepted at edge t; sm_start is high in cycle t+1; RUN begins at t+2.
- s_ready is 0 in IDLE, KICK and RUN. s_data is ignored unless s_valid&s_ready. s_valid may drop for any number of cycles mid-load with no effect on counters.
- load_start is ignored outside IDLE.
- Read path is combinational, so q_i/k_j are valid in the same cycle as the indices.
  - q_i = Q[dk_idx] when dk_idx<D_K, else 0.
  - k_j = K[key_idx][dk_idx] when dk_idx<D_K and key_idx<num_keys, else 0.
  - Reads are available in every state.
- err_oob is set on any RUN cycle with an out-of-range index. It stays set until the next accepted load_start or reset.
- sm_done outside RUN is ignored.
- Reset mid-operation (any state) returns to IDLE per the reset values above; the engine must be reset alongside.
- Arithmetic: counters are unsigned, sized clog2(D_K) for column/q_cnt and NK_WIDTH for row. No operand arithmetic; data is passed through bit-exact.

Decomposition:
- Shared package qkt_pkg holds the state enum (IDLE, LOAD_Q, LOAD_K, KICK, RUN), default INPUT_WIDTH/D_K/IDX_WIDTH constants, and a helper computing the K-buffer address (row*D_K+col).
- One natural sub-module, qkt_operand_mem: Q register file plus K array with a write port and a combinational, range-checked read port.

Test Plan:
- Reset behaviour: assert rst 3 cycles mid-LOAD_K → s_ready=0, busy=0, state IDLE; a fresh load of num_keys=2 then completes normally.
- Basic load and read: load_start with cfg_num_keys=4, 64 Q bytes of value i, then 256 K bytes of value (row*64+col)&0xFF → sm_start high exactly 1 cycle after the last beat; sm_num_queries=4; dk_idx=5/key_idx=3 gives q_i=0x05, k_j=0xC5.
- Stream backpressure: toggle s_valid randomly (50%) during num_keys=1 load → contents identical to the gapless case; sm_start fires after exactly 128 accepted beats.
- Config errors: cfg_num_keys=0, then 129 → err_cfg=1, busy=0, s_ready=0. A following valid load_start clears err_cfg.
- Out-of-range reads: in RUN with num_keys=4, drive key_idx=4 → k_j=0 and err_oob=1. Drive dk_idx=64 → q_i=0.
- End-to-end with the engine: connect to qkt_softmax with N=64 file vectors → engine done, then this block returns to IDLE. A load_start during RUN is ignored; after IDLE a second run completes with matching outputs.
